apb_timer_slave: RTL

APB completer implementing a programmable down-counting timer with interrupt, selected by the master's `PSEL_TIMER` strobe. It decodes a four-register map, inserts a fixed number of wait states, and reports `PSLVERR` for illegal accesses. The timer core decrements on a prescaled tick and flags expiry in a sticky status bit.

---
 rtl/apb_timer_pkg.sv | 24 ++
 rtl/apb_timer_core.sv | 98 +++++++++
 rtl/apb_timer_slave.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register offsets, CTRL field positions
// and the bus handshake state encoding.
package apb_timer_pkg;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_LOAD   = 12'h004;
    localparam logic [11:0] OFF_COUNT  = 12'h008;
    localparam logic [11:0] OFF_STATUS = 12'h00C;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_PS_LSB  = 8;
    localparam int CTRL_PS_MSB  = 15;

    localparam int STATUS_EXPIRED = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } bus_state_t;

endpackage

// File: rtl/apb_timer_core.sv
// Timer core: CTRL fields, prescaler, COUNT/LOAD, sticky EXPIRED and the
// registered interrupt. Driven purely by committed write strobes from the bus side.
module apb_timer_core
    import apb_timer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_we,
    input  logic                  load_we,
    input  logic                  status_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  en,
    output logic                  auto_reload,
    output logic                  irq_en,
    output logic [7:0]            prescale,
    output logic [DATA_WIDTH-1:0] load,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  expired,
    output logic                  irq
);

    logic [7:0] pre;
    logic       wrap;
    logic       tick;
    logic       expire;
    logic       en_rise;

    // >= rather than == so a PRESCALE reduced below the live prescaler still wraps
    assign wrap    = en && (pre >= prescale);
    // a LOAD write swallows a coincident tick
    assign tick    = wrap && !load_we;
    assign expire  = tick && (count == '0);
    assign en_rise = ctrl_we && wdata[CTRL_EN] && !en;

    // Prescaler: free-runs 0..PRESCALE while enabled, restarts on LOAD write or enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else if (load_we || en_rise)
            pre <= '0;
        else if (en)
            pre <= wrap ? 8'd0 : pre + 8'd1;
    end

    // CTRL fields; a bus write overrides the one-shot self-disable in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
        end else if (ctrl_we) begin
            en          <= wdata[CTRL_EN];
            auto_reload <= wdata[CTRL_AR];
            irq_en      <= wdata[CTRL_IRQ_EN];
            prescale    <= wdata[CTRL_PS_MSB:CTRL_PS_LSB];
        end else if (expire && !auto_reload) begin
            en          <= 1'b0;
        end
    end

    // LOAD and COUNT: write copies into both, ticks decrement or reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load  <= '0;
            count <= '0;
        end else if (load_we) begin
            load  <= wdata;
            count <= wdata;
        end else if (tick) begin
            if (count != '0)
                count <= count - 1'b1;
            else if (auto_reload)
                count <= load;
        end
    end

    // Sticky expiry flag; a coincident expiry beats the W1C clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            expired <= 1'b0;
        else if (expire)
            expired <= 1'b1;
        else if (status_we && wdata[STATUS_EXPIRED])
            expired <= 1'b0;
    end

    // Interrupt comes straight from flops so it is glitch-free at the pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= expired && irq_en;
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB completer for the timer: setup/wait/response handshake, address decode,
// error detection, registered read data, and write-strobe generation for the core.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  irq
);

    bus_state_t            state, state_nx;
    logic [3:0]            wcnt, wcnt_nx;
    logic                  resp_go;
    logic                  setup;
    logic [11:0]           offset_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [11:0]           offset;
    logic                  wr;
    logic                  hit_ctrl, hit_load, hit_count, hit_status;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata_mux;
    logic                  commit;

    logic                  en, auto_reload, irq_en, expired;
    logic [7:0]            prescale;
    logic [DATA_WIDTH-1:0] load, count;

    logic                  unused_addr;
    assign unused_addr = ^PADDR[ADDR_WIDTH-1:12];

    assign setup = PSEL && !PENABLE;

    // In IDLE the live bus is decoded (needed when there are no wait states);
    // afterwards the request captured at setup is used.
    assign offset = (state == ST_IDLE) ? PADDR[11:0] : offset_q;
    assign wr     = (state == ST_IDLE) ? PWRITE      : write_q;

    assign hit_ctrl   = (offset == OFF_CTRL);
    assign hit_load   = (offset == OFF_LOAD);
    assign hit_count  = (offset == OFF_COUNT);
    assign hit_status = (offset == OFF_STATUS);
    assign err        = !(hit_ctrl || hit_load || hit_count || hit_status) || (wr && hit_count);

    // Read mux; unlisted CTRL bits read as zero
    always_comb begin
        rdata_mux = '0;
        case (offset)
            OFF_CTRL: begin
                rdata_mux[CTRL_EN]                  = en;
                rdata_mux[CTRL_AR]                  = auto_reload;
                rdata_mux[CTRL_IRQ_EN]              = irq_en;
                rdata_mux[CTRL_PS_MSB:CTRL_PS_LSB]  = prescale;
            end
            OFF_LOAD:   rdata_mux = load;
            OFF_COUNT:  rdata_mux = count;
            OFF_STATUS: rdata_mux[STATUS_EXPIRED] = expired;
            default:    rdata_mux = '0;
        endcase
    end

    // Next-state logic; resp_go marks the edge that loads the response registers
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        resp_go  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = ST_RESP;
                        resp_go  = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                        wcnt_nx  = 4'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_nx = ST_IDLE;
                end else if (wcnt == 4'(WAIT_STATES - 1)) begin
                    state_nx = ST_RESP;
                    resp_go  = 1'b1;
                end else begin
                    wcnt_nx  = wcnt + 4'd1;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register and request capture at setup
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            wcnt     <= '0;
            offset_q <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (state == ST_IDLE && setup) begin
                offset_q <= PADDR[11:0];
                write_q  <= PWRITE;
                wdata_q  <= PWDATA;
            end
        end
    end

    // Registered response: valid only during the single RESP cycle
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else if (resp_go) begin
            PREADY  <= 1'b1;
            PSLVERR <= err;
            PRDATA  <= (!wr && !err) ? rdata_mux : '0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end
    end

    // Writes take effect at the edge closing the RESP cycle, error-free only
    assign commit = (state == ST_RESP) && write_q && !PSLVERR;

    apb_timer_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .ctrl_we     (commit && (offset_q == OFF_CTRL)),
        .load_we     (commit && (offset_q == OFF_LOAD)),
        .status_we   (commit && (offset_q == OFF_STATUS)),
        .wdata       (wdata_q),
        .en          (en),
        .auto_reload (auto_reload),
        .irq_en      (irq_en),
        .prescale    (prescale),
        .load        (load),
        .count       (count),
        .expired     (expired),
        .irq         (irq)
    );

endmodule
